// File: rtl/led_pkg.sv
// Shared types and defaults for the port activity LED driver.
package led_pkg;

  typedef enum logic [1:0] {IDLE, BLINK_OFF, BLINK_ON} led_state_t;

  localparam int TICK_LOG2_DEF = 20;
  localparam int OFF_TICKS_DEF = 2;
  localparam int ON_TICKS_DEF  = 2;

  // Tick down-counter must hold the larger of the two phase lengths.
  function automatic int cnt_width(input int off_t, input int on_t);
    return $clog2(((off_t > on_t) ? off_t : on_t) + 1);
  endfunction

endpackage

// File: rtl/led_blink_fsm.sv
// One port's blink sequencer: IDLE shows link, traffic forces a dark then lit blink.
module led_blink_fsm
  import led_pkg::*;
#(
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic act_i,
  input  logic link_i,
  output logic led_o
);

  localparam int CW = cnt_width(OFF_TICKS, ON_TICKS);
  localparam logic [CW-1:0] OFF_LD = CW'(OFF_TICKS);
  localparam logic [CW-1:0] ON_LD  = CW'(ON_TICKS);
  localparam logic [CW-1:0] ONE    = CW'(1);

  led_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          led_q, led_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (act_i) begin
          state_d = BLINK_OFF;
          cnt_d   = OFF_LD;
          pend_d  = 1'b0;
        end
      end
      BLINK_OFF: begin
        pend_d = pend_q | act_i;
        if (tick_i) begin
          if (cnt_q == ONE) begin
            state_d = BLINK_ON;
            cnt_d   = ON_LD;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      BLINK_ON: begin
        pend_d = pend_q | act_i;
        if (tick_i) begin
          if (cnt_q == ONE) begin
            // A pulse on the closing tick chains straight into the next blink.
            if (pend_q | act_i) begin
              state_d = BLINK_OFF;
              cnt_d   = OFF_LD;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    led_d = 1'b0;
    unique case (state_q)
      IDLE:      led_d = link_i;
      BLINK_OFF: led_d = 1'b0;
      BLINK_ON:  led_d = 1'b1;
      default:   led_d = 1'b0;
    endcase
  end

  assign led_o = led_q;

endmodule

// File: rtl/port_activity_leds.sv
// Per-port link/activity LED driver with a shared slow tick.
// LED_LINK_EN: adds link_up and shows link state while idle; otherwise idle LEDs are dark.
module port_activity_leds
  import led_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int TICK_LOG2 = TICK_LOG2_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [NPORTS-1:0] act_pulse,
`ifdef LED_LINK_EN
  input  logic [NPORTS-1:0] link_up,
`endif
  output logic [NPORTS-1:0] LEDG
);

  logic [TICK_LOG2-1:0] presc_q, presc_d;
  logic                 tick;
  logic [NPORTS-1:0]    link_w;

  assign presc_d = presc_q + 1'b1;
  assign tick    = &presc_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) presc_q <= '0;
    else       presc_q <= presc_d;
  end

`ifdef LED_LINK_EN
  assign link_w = link_up;
`else
  assign link_w = '0;
`endif

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    led_blink_fsm #(
      .OFF_TICKS(OFF_TICKS),
      .ON_TICKS (ON_TICKS)
    ) u_fsm (
      .clk_i (CLOCK_50),
      .rst_i (RESET),
      .tick_i(tick),
      .act_i (act_pulse[i]),
      .link_i(link_w[i]),
      .led_o (LEDG[i])
    );
  end

endmodule

// File: tb/tb_port_activity_leds.sv
// Scoreboard bench: absolute-cycle blink model predicts LEDG, monitor compares every cycle.
module tb_port_activity_leds;

  localparam int NP   = 4;
  localparam int TL   = 2;
  localparam int OFFT = 2;
  localparam int ONT  = 2;
  localparam int P    = 1 << TL;
`ifdef LED_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic [NP-1:0] act_pulse = '0;
  logic [NP-1:0] link_up = '1;
  logic [NP-1:0] LEDG;

  port_activity_leds #(
    .NPORTS(NP), .TICK_LOG2(TL), .OFF_TICKS(OFFT), .ON_TICKS(ONT)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .act_pulse(act_pulse),
`ifdef LED_LINK_EN
    .link_up  (link_up),
`endif
    .LEDG     (LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [NP-1:0] exp_q[$];
  logic [NP-1:0] mon_e;
  int nchecks = 0;
  int nerrs = 0;

  // Model: mode 0 idle, 1 dark, 2 lit; end_c = cycle index of the tick closing the phase.
  int mode[NP];
  int end_c[NP];
  bit pend[NP];
  int k = 0;
  logic [NP-1:0] lnk;

  function automatic int next_tick_after(input int kk);
    int t;
    t = kk + 1;
    return t + ((P - 1) - (t % P));
  endfunction

  task automatic step(input logic rst, input logic [NP-1:0] lk, input logic [NP-1:0] a);
    logic [NP-1:0] e;
    @(negedge CLOCK_50);
    RESET = rst;
    link_up = lk;
    act_pulse = a;
    e = '0;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mode[p] = 0;
        pend[p] = 1'b0;
        end_c[p] = 0;
      end
      k = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        e[p] = (mode[p] == 0) ? (LINK_EN & lk[p]) : (mode[p] == 2);
        case (mode[p])
          0: if (a[p]) begin
               mode[p] = 1;
               end_c[p] = next_tick_after(k) + (OFFT - 1) * P;
               pend[p] = 1'b0;
             end
          1: begin
               pend[p] = pend[p] | a[p];
               if (k == end_c[p]) begin
                 mode[p] = 2;
                 end_c[p] = k + ONT * P;
               end
             end
          default: begin
               if (k == end_c[p]) begin
                 if (pend[p] || a[p]) begin
                   mode[p] = 1;
                   end_c[p] = k + OFFT * P;
                   pend[p] = 1'b0;
                 end else begin
                   mode[p] = 0;
                 end
               end else begin
                 pend[p] = pend[p] | a[p];
               end
             end
        endcase
      end
      k++;
    end
    exp_q.push_back(e);
  endtask

  always @(posedge CLOCK_50) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      nchecks++;
      if (LEDG !== mon_e) begin
        nerrs++;
        $display("FAIL ledg t=%0t: got %b expected %b", $time, LEDG, mon_e);
      end
    end
  end

  initial begin
    bit done;
    logic [NP-1:0] a;
    lnk = '1;
    // Reset held 3 cycles with link up, then idle link tracking
    repeat (3) step(1'b1, lnk, '0);
    repeat (4) step(1'b0, lnk, '0);

    // Single pulse on port 0
    step(1'b0, lnk, 4'b0001);
    repeat (24) step(1'b0, lnk, '0);

    // Continuous traffic on port 1
    for (int c = 0; c < 100; c++) step(1'b0, lnk, (c % 3 == 0) ? 4'b0010 : 4'b0000);
    repeat (24) step(1'b0, lnk, '0);

    // Pulse on port 2 exactly on the tick that closes its lit phase
    step(1'b0, lnk, 4'b0100);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mode[2] == 2 && k == end_c[2]) begin
        step(1'b0, lnk, 4'b0100);
        done = 1'b1;
      end else begin
        step(1'b0, lnk, '0);
      end
    end
    nchecks++;
    if (!done) begin
      nerrs++;
      $display("FAIL coincident_pulse: got no closing tick within 40 cycles, expected one");
    end
    repeat (24) step(1'b0, lnk, '0);

    // Link on port 3 drops while dark
    step(1'b0, lnk, 4'b1000);
    repeat (2) step(1'b0, lnk, '0);
    lnk[3] = 1'b0;
    repeat (24) step(1'b0, lnk, '0);

    // Random traffic and link flaps
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) a[p] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) lnk[$urandom_range(0, NP - 1)] ^= 1'b1;
      step(1'b0, lnk, a);
    end
    lnk = '1;
    repeat (4) step(1'b0, lnk, '0);

    // Reset mid-blink on all ports, then an immediate fresh blink
    step(1'b0, lnk, '1);
    repeat (3) step(1'b0, lnk, '0);
    repeat (2) step(1'b1, lnk, '0);
    step(1'b0, lnk, '1);
    repeat (24) step(1'b0, lnk, '0);

    @(posedge CLOCK_50);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/port_activity_leds.md
# port_activity_leds

Per-port link/activity LED driver that sits directly downstream of the switch's port logic and drives the board's green LEDs. It consumes one-cycle frame-event pulses and link-status levels from each switch port and turns them into human-visible blinks using a shared slow tick. This replaces the free-running bring-up blinker as the consumer of the LEDG pins.

## Interface
Parameters:
- NPORTS, 4: number of switch ports and LEDs driven.
- TICK_LOG2, 20: tick period P = 2^TICK_LOG2 cycles (about 21 ms at 50 MHz).
- OFF_TICKS, 2: length of the dark phase of a blink, in ticks (≥1).
- ON_TICKS, 2: minimum lit phase after a blink, in ticks (≥1).

Ports:
- CLOCK_50, input, 1: the single clock.
- RESET, input, 1: synchronous, active-high reset.
- act_pulse, input, NPORTS: one-cycle pulse per frame received or sent on port i.
- link_up, input, NPORTS: link status level per port. Present only with LED_LINK_EN.
- LEDG, output, NPORTS: registered LED drive; 1 = lit.

## Operation
- Shared prescaler: a TICK_LOG2-bit counter increments every cycle and wraps. `tick` is a 1-cycle pulse when the counter is all ones.
- Each port has an independent FSM with a tick down-counter and a `pending` flag:
  - IDLE: LEDG[i] = link_up[i], or 0 without LED_LINK_EN. On act_pulse[i], go to BLINK_OFF and load cnt = OFF_TICKS.
  - BLINK_OFF: LEDG[i] = 0. cnt decrements on each tick. On a tick with cnt == 1, go to BLINK_ON and load cnt = ON_TICKS.
  - BLINK_ON: LEDG[i] = 1. On a tick with cnt == 1:
    - if pending (or act_pulse[i] in that same cycle), go to BLINK_OFF and clear pending;
    - otherwise go to IDLE.
- `pending` behaviour:
  - set by act_pulse[i] while in BLINK_OFF or BLINK_ON;
  - multiple pulses collapse into one;
  - cleared on every entry into BLINK_OFF.
- Continuous traffic therefore produces a steady square blink of period (OFF_TICKS + ON_TICKS)·P. Traffic never holds the LED dark.
- A blink always completes, even if link_up falls mid-blink. link_up is only reflected in IDLE.
- Ports never interact. Simultaneous pulses on several ports are handled independently.

## Timing
- Reset:
  - LEDG = 0, prescaler = 0, all FSMs in IDLE, cnt = 0, pending = 0.
  - Reset asserted mid-blink aborts the blink. LEDG = 0 on the cycle after the reset edge.
- Latency: act_pulse[i] sampled at edge N puts the FSM in BLINK_OFF at N, and LEDG[i] = 0 after edge N+1 (one registered stage).
- IDLE link tracking: LEDG[i] follows link_up[i] with a 1-cycle delay.
- Dark phase length lies in [(OFF_TICKS−1)·P+1, OFF_TICKS·P] cycles, depending on prescaler phase at entry. The lit phase follows the same rule with ON_TICKS.
- An act_pulse in the same cycle as the tick that ends BLINK_ON produces no lit gap beyond ON_TICKS: the FSM re-enters BLINK_OFF directly.
- Tick counter wraps from 2^TICK_LOG2−1 to 0 with no missed or double tick.

## Configuration
- LED_LINK_EN:
  - Defined: the link_up port exists, and IDLE drives link_up[i] (lit while link is up, blinks dark on traffic).
  - Undefined: no link_up port, and IDLE drives 0, giving activity-only LEDs (dark, flash on traffic). BLINK_OFF/BLINK_ON are unchanged.

## Structure
- Package `led_pkg`:
  - `led_state_t` enum (IDLE, BLINK_OFF, BLINK_ON);
  - default constants for TICK_LOG2, OFF_TICKS, ON_TICKS;
  - counter-width function `$clog2(max(OFF_TICKS, ON_TICKS)+1)`.
- Top holds the shared prescaler and a generate loop instantiating sub-module `led_blink_fsm` (one port: tick, act, link, led) NPORTS times.

## Test plan
Bench parameters: TICK_LOG2 = 2 (P = 4), OFF_TICKS = 2, ON_TICKS = 2, NPORTS = 4, LED_LINK_EN defined.
- Reset: hold RESET 3 cycles with link_up = 4'hF → LEDG = 0 during reset, LEDG = 4'hF one cycle after release.
- Single pulse on port 0 (link up):
  - LEDG[0] falls 1 cycle later;
  - stays 0 for 5–8 cycles, then 1 for 5–8 cycles;
  - FSM back in IDLE; other LEDs stay 1.
- Pulse on port 1 every 3 cycles for 100 cycles → LEDG[1] toggles with period 16 cycles (8 dark / 8 lit, ±3 for phase). No lit gap longer than 8 cycles; never dark longer than 8.
- act_pulse[2] coincident with the BLINK_ON-ending tick → BLINK_OFF entered directly; LEDG[2] falls the next cycle.
- link_up[3] drops mid-BLINK_OFF → blink completes (lit phase shown), then LEDG[3] = 0 in IDLE.
- RESET asserted mid-blink on all ports → all LEDG = 0 next cycle; after release, an immediate act_pulse starts a fresh full-length blink.
